// File: rtl/rgb_hsv_core.sv
// RGB (2.16 normalised) to HSV converter for one pixel at a time.
// A single restoring divider is shared: it computes saturation first, then the hue fraction.
module rgb_hsv_core #(
  parameter int FW = 16,
  parameter int IW = 18
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   ri,
  input  logic [IW-1:0]   gi,
  input  logic [IW-1:0]   bi,
  input  logic [7:0]      R8,
  input  logic [7:0]      G8,
  input  logic [7:0]      B8,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FW+2:0]   h,
  output logic [FW:0]     s,
  output logic [IW-1:0]   v,
  output logic [7:0]      RO,
  output logic [7:0]      GO,
  output logic [7:0]      BO
);

  localparam int CW = $clog2(FW + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SORT  = 3'd1,
    S_DIV_S = 3'd2,
    S_DIV_H = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]      r8_q, r8_d, g8_q, g8_d, b8_q, b8_d;
  logic [IW-1:0]   max_q, max_d, delta_q, delta_d, hnum_q, hnum_d;
  logic [2:0]      sector_q, sector_d;
  logic [IW+1:0]   rem_q, rem_d;
  logic [IW-1:0]   den_q, den_d;
  logic [FW:0]     quot_q, quot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW:0]     sres_q, sres_d;
  logic [FW:0]     hq_q, hq_d;
  logic [FW+2:0]   h_q, h_d;
  logic [FW:0]     s_q, s_d;
  logic [IW-1:0]   v_q, v_d;
  logic [7:0]      ro_q, ro_d, go_q, go_d, bo_q, bo_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  // Sort stage signals
  logic [IW-1:0]   max_s, min_s, delta_s, hnum_s;
  logic [2:0]      sector_s;

  // Divider step signals
  logic            qbit_s;
  logic [IW+1:0]   rem_sub_s, rem_next_s;
  logic [FW:0]     quot_next_s;

  // Hue assembly signals
  logic [FW+3:0]   h_full_s;
  logic [FW+2:0]   h_final_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign h         = h_q;
  assign s         = s_q;
  assign v         = v_q;
  assign RO        = ro_q;
  assign GO        = go_q;
  assign BO        = bo_q;

  // Max/min, sector classification and hue numerator from the captured channels
  always_comb begin
    max_s    = r_q;
    min_s    = r_q;
    sector_s = 3'd0;
    hnum_s   = '0;
    if (g_q > max_s) begin
      max_s = g_q;
    end else begin
      max_s = max_s;
    end
    if (b_q > max_s) begin
      max_s = b_q;
    end else begin
      max_s = max_s;
    end
    if (g_q < min_s) begin
      min_s = g_q;
    end else begin
      min_s = min_s;
    end
    if (b_q < min_s) begin
      min_s = b_q;
    end else begin
      min_s = min_s;
    end
    delta_s = max_s - min_s;
    // First matching sector wins; ties resolve towards the lower sector
    if (r_q >= g_q && g_q >= b_q) begin
      sector_s = 3'd0;
      hnum_s   = g_q - b_q;
    end else if (g_q > r_q && r_q >= b_q) begin
      sector_s = 3'd1;
      hnum_s   = g_q - r_q;
    end else if (g_q >= b_q && b_q > r_q) begin
      sector_s = 3'd2;
      hnum_s   = b_q - r_q;
    end else if (b_q > g_q && g_q > r_q) begin
      sector_s = 3'd3;
      hnum_s   = b_q - g_q;
    end else if (b_q > r_q && r_q >= g_q) begin
      sector_s = 3'd4;
      hnum_s   = r_q - g_q;
    end else if (r_q >= b_q && b_q > g_q) begin
      sector_s = 3'd5;
      hnum_s   = r_q - b_q;
    end else begin
      sector_s = 3'd0;
      hnum_s   = '0;
    end
  end

  // One restoring-division step; a zero divisor yields an all-zero quotient
  always_comb begin
    if ((rem_q >= {2'b00, den_q}) && (den_q != '0)) begin
      qbit_s    = 1'b1;
      rem_sub_s = rem_q - {2'b00, den_q};
    end else begin
      qbit_s    = 1'b0;
      rem_sub_s = rem_q;
    end
    rem_next_s  = {rem_sub_s[IW:0], 1'b0};
    quot_next_s = {quot_q[FW-1:0], qbit_s};
  end

  // Final hue: sector offset plus fraction, guarded against out-of-range results
  always_comb begin
    h_full_s = {1'b0, sector_q, {FW{1'b0}}} + {3'b000, hq_q};
    if (h_full_s >= ((FW+4)'(6) << FW)) begin
      h_final_s = '0;
    end else begin
      h_final_s = h_full_s[FW+2:0];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    r8_d        = r8_q;
    g8_d        = g8_q;
    b8_d        = b8_q;
    max_d       = max_q;
    delta_d     = delta_q;
    hnum_d      = hnum_q;
    sector_d    = sector_q;
    rem_d       = rem_q;
    den_d       = den_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    sres_d      = sres_q;
    hq_d        = hq_q;
    h_d         = h_q;
    s_d         = s_q;
    v_d         = v_q;
    ro_d        = ro_q;
    go_d        = go_q;
    bo_d        = bo_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          r_d     = ri;
          g_d     = gi;
          b_d     = bi;
          r8_d    = R8;
          g8_d    = G8;
          b8_d    = B8;
          state_d = S_SORT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SORT: begin
        max_d    = max_s;
        delta_d  = delta_s;
        hnum_d   = hnum_s;
        sector_d = sector_s;
        rem_d    = {2'b00, delta_s};
        den_d    = max_s;
        quot_d   = '0;
        cnt_d    = CW'(FW);
        state_d  = S_DIV_S;
      end
      S_DIV_S: begin
        rem_d  = rem_next_s;
        quot_d = quot_next_s;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          sres_d  = quot_next_s;
          rem_d   = {2'b00, hnum_q};
          den_d   = delta_q;
          quot_d  = '0;
          cnt_d   = CW'(FW);
          state_d = S_DIV_H;
        end else begin
          state_d = S_DIV_S;
        end
      end
      S_DIV_H: begin
        rem_d  = rem_next_s;
        quot_d = quot_next_s;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          hq_d    = quot_next_s;
          state_d = S_DONE;
        end else begin
          state_d = S_DIV_H;
        end
      end
      S_DONE: begin
        // First DONE cycle loads the result registers; then wait for the consumer
        if (!out_valid_q) begin
          h_d         = h_final_s;
          s_d         = sres_q;
          v_d         = max_q;
          ro_d        = r8_q;
          go_d        = g8_q;
          bo_d        = b8_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      r8_q        <= '0;
      g8_q        <= '0;
      b8_q        <= '0;
      max_q       <= '0;
      delta_q     <= '0;
      hnum_q      <= '0;
      sector_q    <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      sres_q      <= '0;
      hq_q        <= '0;
      h_q         <= '0;
      s_q         <= '0;
      v_q         <= '0;
      ro_q        <= '0;
      go_q        <= '0;
      bo_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      r8_q        <= r8_d;
      g8_q        <= g8_d;
      b8_q        <= b8_d;
      max_q       <= max_d;
      delta_q     <= delta_d;
      hnum_q      <= hnum_d;
      sector_q    <= sector_d;
      rem_q       <= rem_d;
      den_q       <= den_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      sres_q      <= sres_d;
      hq_q        <= hq_d;
      h_q         <= h_d;
      s_q         <= s_d;
      v_q         <= v_d;
      ro_q        <= ro_d;
      go_q        <= go_d;
      bo_q        <= bo_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_rgb_hsv_core.sv
// Scoreboard bench for rgb_hsv_core: directed pixels with hand-computed HSV results.
module tb_rgb_hsv_core;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] ri, gi, bi;
  logic [7:0]  R8, G8, B8;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] h;
  logic [16:0] s;
  logic [17:0] v;
  logic [7:0]  RO, GO, BO;

  rgb_hsv_core #(.FW(16), .IW(18)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .ri(ri), .gi(gi), .bi(bi), .R8(R8), .G8(G8), .B8(B8),
    .out_valid(out_valid), .out_ready(out_ready),
    .h(h), .s(s), .v(v), .RO(RO), .GO(GO), .BO(BO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [18:0] h;
    logic [16:0] s;
    logic [17:0] v;
    logic [7:0]  ro, go, bo;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   inflight = 0;
  bit   seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented result against the head of the scoreboard
  always @(negedge CLK) begin
    if (RST_N && out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - sbq[0].acc, 32'd36);
          seen = 1'b1;
        end
        chk("h",  {13'd0, h},  {13'd0, sbq[0].h});
        chk("s",  {15'd0, s},  {15'd0, sbq[0].s});
        chk("v",  {14'd0, v},  {14'd0, sbq[0].v});
        chk("RO", {24'd0, RO}, {24'd0, sbq[0].ro});
        chk("GO", {24'd0, GO}, {24'd0, sbq[0].go});
        chk("BO", {24'd0, BO}, {24'd0, sbq[0].bo});
        if (out_ready) begin
          void'(sbq.pop_front());
          seen = 1'b0;
          inflight--;
        end
      end
    end
  end

  task automatic send(input logic [17:0] r, input logic [17:0] g, input logic [17:0] b,
                      input logic [7:0] r8, input logic [7:0] g8, input logic [7:0] b8,
                      input logic [18:0] eh, input logic [16:0] es, input logic [17:0] ev);
    exp_t e;
    int   t;
    inflight++;
    @(negedge CLK);
    ri = r; gi = g; bi = b; R8 = r8; G8 = g8; B8 = b8;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      inflight--;
    end else begin
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      e.h = eh; e.s = es; e.v = ev; e.ro = r8; e.go = g8; e.bo = b8;
      e.acc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (inflight > 0 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    if (inflight > 0) chk("drain_timeout", inflight, 32'd0);
  endtask

  initial begin
    int t;
    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ri = '0; gi = '0; bi = '0; R8 = '0; G8 = '0; B8 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_h", {13'd0, h}, 32'd0);
    chk("rst_s", {15'd0, s}, 32'd0);
    chk("rst_v", {14'd0, v}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // T1..T4 and further sectors
    send(18'h10000, 18'h00000, 18'h00000, 8'hFF, 8'h00, 8'h00, 19'h00000, 17'h10000, 18'h10000);
    send(18'h08080, 18'h08080, 18'h08080, 8'h80, 8'h80, 8'h80, 19'h00000, 17'h00000, 18'h08080);
    send(18'h00000, 18'h00000, 18'h00000, 8'h00, 8'h00, 8'h00, 19'h00000, 17'h00000, 18'h00000);
    send(18'h10000, 18'h08000, 18'h00000, 8'hFF, 8'h80, 8'h00, 19'h08000, 17'h10000, 18'h10000);
    send(18'h04000, 18'h10000, 18'h04000, 8'h40, 8'hFF, 8'h40, 19'h20000, 17'h0C000, 18'h10000);
    send(18'h00000, 18'h10000, 18'h08000, 8'h01, 8'h02, 8'h03, 19'h28000, 17'h10000, 18'h10000);
    send(18'h00000, 18'h08000, 18'h10000, 8'h11, 8'h22, 8'h33, 19'h38000, 17'h10000, 18'h10000);
    send(18'h08000, 18'h00000, 18'h10000, 8'h44, 8'h55, 8'h66, 19'h48000, 17'h10000, 18'h10000);
    send(18'h10000, 18'h00000, 18'h04000, 8'h77, 8'h88, 8'h99, 19'h5C000, 17'h10000, 18'h10000);
    send(18'h0C000, 18'h06000, 18'h03000, 8'hC0, 8'h60, 8'h30, 19'h05555, 17'h0C000, 18'h0C000);
    drain();

    // T5 backpressure with a second pixel waiting upstream
    out_ready = 1'b0;
    send(18'h10000, 18'h08000, 18'h00000, 8'hA1, 8'hB2, 8'hC3, 19'h08000, 17'h10000, 18'h10000);
    fork
      send(18'h04000, 18'h10000, 18'h04000, 8'hD4, 8'hE5, 8'hF6, 19'h20000, 17'h0C000, 18'h10000);
    join_none
    t = 0;
    while (!out_valid && t < 60) begin
      @(negedge CLK);
      t++;
    end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(negedge CLK);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    @(posedge CLK);
    #1 out_ready = 1'b1;
    drain();

    // T6 reset during DIV_H
    send(18'h10000, 18'h08000, 18'h00000, 8'h5A, 8'hA5, 8'h3C, 19'h08000, 17'h10000, 18'h10000);
    repeat (24) @(negedge CLK);
    RST_N = 1'b0;
    sbq.delete();
    inflight = 0;
    seen = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("mid_rst_h",  {13'd0, h},  32'd0);
    chk("mid_rst_s",  {15'd0, s},  32'd0);
    chk("mid_rst_v",  {14'd0, v},  32'd0);
    chk("mid_rst_RO", {24'd0, RO}, 32'd0);
    chk("mid_rst_GO", {24'd0, GO}, 32'd0);
    chk("mid_rst_BO", {24'd0, BO}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("mid_rst_in_ready_release", {31'd0, in_ready}, 32'd1);
    repeat (40) @(negedge CLK);
    send(18'h10000, 18'h00000, 18'h00000, 8'hFF, 8'h00, 8'h00, 19'h00000, 17'h10000, 18'h10000);
    drain();

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
